// File: rtl/apu_pkg.sv
// Shared constants for the APU master control block: register indices,
// the power bit position and the frame-sequencer step decode masks.
package apu_pkg;

  localparam logic [1:0] REG_VOL  = 2'd0;
  localparam logic [1:0] REG_PANL = 2'd1;
  localparam logic [1:0] REG_PANR = 2'd2;
  localparam logic [1:0] REG_CTL  = 2'd3;

  localparam int CTL_POWER_BIT = 7;

  // Bit s of each mask is set when that tick fires at sequencer step s.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

endpackage

// File: rtl/apu_frame_seq.sv
// Frame sequencer: selects the frame tick source, steps an 8-state
// sequence and emits one-cycle registered length/sweep/envelope pulses.
module apu_frame_seq
  import apu_pkg::*;
#(
  parameter int FAST_DIV = 16
) (
  input  logic clk,
  input  logic nreset2,
  input  logic power,
  input  logic clear,
  input  logic tick_512,
  input  logic t1_nt2,
  output logic len_tick,
  output logic sweep_tick,
  output logic env_tick
);

  localparam int CW = $clog2(FAST_DIV);

  logic [CW-1:0] fast_cnt;
  logic [2:0]    step;
  logic          ftick;

  // The fast counter wraps on its all-ones value since FAST_DIV is a power of 2.
  assign ftick = power & (t1_nt2 ? (fast_cnt == {CW{1'b1}}) : tick_512);

  always_ff @(posedge clk) begin
    if (!nreset2 || clear) begin
      fast_cnt   <= '0;
      step       <= 3'd0;
      len_tick   <= 1'b0;
      sweep_tick <= 1'b0;
      env_tick   <= 1'b0;
    end else begin
      if (power) fast_cnt <= fast_cnt + 1'b1;
      len_tick   <= ftick & LEN_STEPS[step];
      sweep_tick <= ftick & SWEEP_STEPS[step];
      env_tick   <= ftick & ENV_STEPS[step];
      if (ftick) step <= step + 3'd1;
    end
  end

endmodule

// File: rtl/apu_control_n.sv
// APU master control: volume, L/R routing and power registers for NCH
// channels, clock-enable generation and the frame sequencer.
module apu_control_n
  import apu_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int FAST_DIV = 16
) (
  input  logic           apuv_4mhz,
  input  logic           nreset2,
  input  logic [1:0]     addr,
  input  logic           wr,
  input  logic           rd,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           dout_oe,
  input  logic           tick_512,
  input  logic           t1_nt2,
  input  logic [NCH-1:0] ch_active,
  output logic           apu_reset,
  output logic           ce_2mhz,
  output logic           ce_1mhz,
  output logic           len_tick,
  output logic           sweep_tick,
  output logic           env_tick,
  output logic [NCH-1:0] lmixer,
  output logic [NCH-1:0] rmixer,
  output logic [2:0]     lvol,
  output logic [2:0]     rvol,
  output logic           vin_l,
  output logic           vin_r
);

  logic           power;
  logic           power_next;
  logic [7:0]     vol;
  logic [NCH-1:0] panl;
  logic [NCH-1:0] panr;
  logic [1:0]     phase;
  logic [7:0]     panl_rd;
  logic [7:0]     panr_rd;
  logic [7:0]     ctl_rd;

  assign power_next = (wr && addr == REG_CTL) ? din[CTL_POWER_BIT] : power;

  // Powering off clears every register in the block on the same edge.
  always_ff @(posedge apuv_4mhz) begin
    if (!nreset2) begin
      power <= 1'b0;
      vol   <= 8'h00;
      panl  <= '0;
      panr  <= '0;
      phase <= 2'd0;
    end else begin
      power <= power_next;
      if (!power_next) begin
        vol   <= 8'h00;
        panl  <= '0;
        panr  <= '0;
        phase <= 2'd0;
      end else begin
        if (power) phase <= phase + 2'd1;
        if (power && wr) begin
          case (addr)
            REG_VOL:  vol  <= din;
            REG_PANL: panl <= din[NCH-1:0];
            REG_PANR: panr <= din[NCH-1:0];
            default:  ;
          endcase
        end
      end
    end
  end

  apu_frame_seq #(
    .FAST_DIV (FAST_DIV)
  ) u_frame_seq (
    .clk        (apuv_4mhz),
    .nreset2    (nreset2),
    .power      (power),
    .clear      (~power_next),
    .tick_512   (tick_512),
    .t1_nt2     (t1_nt2),
    .len_tick   (len_tick),
    .sweep_tick (sweep_tick),
    .env_tick   (env_tick)
  );

  assign apu_reset = ~power;
  assign ce_2mhz   = power & phase[0];
  assign ce_1mhz   = power & (phase == 2'd3);
  assign lmixer    = panl;
  assign rmixer    = panr;
  assign vin_l     = vol[7];
  assign lvol      = vol[6:4];
  assign vin_r     = vol[3];
  assign rvol      = vol[2:0];
  assign dout_oe   = rd;

  // Unused upper bits of the pan and control registers read back as ones.
  always_comb begin
    panl_rd                = 8'hFF;
    panl_rd[NCH-1:0]       = panl;
    panr_rd                = 8'hFF;
    panr_rd[NCH-1:0]       = panr;
    ctl_rd                 = 8'h7F;
    ctl_rd[CTL_POWER_BIT]  = power;
    ctl_rd[NCH-1:0]        = ch_active & {NCH{power}};
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      REG_VOL:  dout = vol;
      REG_PANL: dout = panl_rd;
      REG_PANR: dout = panr_rd;
      default:  dout = ctl_rd;
    endcase
  end

endmodule

// File: doc/apu_control_n.md
Name: apu_control_n

Overview:
- Parametrised successor to the APU master control block.
- Holds master volume, per-channel L/R routing and power control for NCH channels. Generates clock enables and an 8-step frame sequencer.
- Sits between the CPU register bus and the channel/mixer blocks, on a single 4 MHz domain.
- Adds register-decoded addressing, write gating while powered off, and frame-sequencer tick outputs.

Parameters:
NCH, 4, number of sound channels (1..7)
FAST_DIV, 16, cycles per frame tick in test mode (power of 2, >=4)

Ports:
apuv_4mhz  in  1  system clock, all state on rising edge
nreset2  in  1  synchronous active-low reset
addr  in  2  register select: 0=VOL, 1=PANL, 2=PANR, 3=CTL
wr  in  1  register write strobe, one cycle
rd  in  1  register read enable
din  in  8  write data
dout  out  8  read data, combinational
dout_oe  out  1  = rd
tick_512  in  1  one-cycle pulse from divider, 512 Hz
t1_nt2  in  1  test mode: frame tick from internal FAST_DIV counter instead of tick_512
ch_active  in  NCH  channel running flags, active-high
apu_reset  out  1  high while powered off
ce_2mhz  out  1  clock enable
ce_1mhz  out  1  clock enable
len_tick  out  1  length-counter pulse
sweep_tick  out  1  sweep pulse
env_tick  out  1  envelope pulse
lmixer  out  NCH  left routing enables
rmixer  out  NCH  right routing enables
lvol  out  3  left master volume
rvol  out  3  right master volume
vin_l  out  1  VIN-to-left enable
vin_r  out  1  VIN-to-right enable

Behaviour:
- Reset (nreset2=0 at clock edge) clears:
  - power=0, VOL=0, PANL=0, PANR=0;
  - step=0, FAST_DIV counter=0, clock-enable phase=0;
  - all tick and ce outputs 0;
  - apu_reset=1.
- Register map:
  - VOL = {vin_l, lvol[2:0], vin_r, rvol[2:0]};
  - PANL[NCH-1:0] -> lmixer; PANR[NCH-1:0] -> rmixer;
  - CTL bit7 = power.
- Writes land at the clock edge with wr=1. Outputs update the same edge, so they are visible the next cycle.
- Write gating while power=0:
  - writes to VOL, PANL and PANR are ignored;
  - writes to CTL are always honoured.
- CTL write, din[7]=0 while powered: power, VOL, PANL, PANR, step, phase and FAST_DIV counter clear on the same edge; apu_reset=1 the next cycle.
- CTL write, din[7]=1 while off: power=1, apu_reset=0 the next cycle. Step and counters start from 0.
- CTL writes to bits 6:0 have no effect.
- Read data (combinational):
  - VOL returns the register;
  - PANL/PANR return {ones, reg[NCH-1:0]};
  - CTL returns {power, ones in bits 6:NCH, ch_active & {NCH{power}}}.
- Clock enables (all 0 while power=0):
  - a 2-bit phase counter runs while power=1, starting at 0 after power-on;
  - ce_2mhz=1 when phase[0]==1;
  - ce_1mhz=1 when phase==3.
- Frame tick source:
  - ftick = tick_512 when t1_nt2=0;
  - when t1_nt2=1, ftick = internal counter wrap every FAST_DIV cycles; the counter runs only while power=1.
- Frame sequencer: on an ftick cycle with power=1, the outputs decode from the current step, then step increments mod 8.
  - len_tick: step in {0,2,4,6};
  - sweep_tick: step in {2,6};
  - env_tick: step == 7.
- Tick pulses are registered: one cycle long, appearing the cycle after ftick.
- Simultaneous events:
  - power-off write coinciding with ftick: power-off wins, no tick pulse, step=0;
  - power-on write coinciding with ftick: the tick is ignored, step stays 0.
- Reset asserted mid-operation overrides everything on that edge.
- step wraps 7 -> 0 silently.

Decomposition:
- Package apu_pkg holds:
  - register index constants (REG_VOL, REG_PANL, REG_PANR, REG_CTL);
  - CTL_POWER_BIT;
  - the step decode constants (length/sweep/envelope step masks).
- One sub-module, apu_frame_seq: ftick select, FAST_DIV counter, 3-bit step counter and the three registered tick outputs, with power as a synchronous clear.

Test Plan:
- Reset, then read CTL with ch_active=4'b1010 -> dout=8'h70 (off, channel bits masked), apu_reset=1, all ce and ticks 0.
- Write CTL=8'h80, then VOL=8'h77, PANL=8'h0F -> lvol=7, rvol=7, vin_l=0, lmixer=4'hF; CTL read with ch_active=4'b0101 -> 8'hF5.
- While off, write PANR=8'h0C -> rmixer stays 0 and PANR reads 8'hF0; after power-on, the same write -> rmixer=4'hC.
- Powered on, 8 tick_512 pulses -> len_tick on pulses 1,3,5,7, sweep_tick on 3,7, env_tick on 8, each one cycle late; the 9th pulse -> len_tick again (wrap).
- t1_nt2=1, FAST_DIV=16 -> ftick every 16 cycles; ce_2mhz toggles every cycle, ce_1mhz pulses every 4th cycle.
- Write CTL=8'h00 on the same cycle as tick_512 at step 3 -> no tick pulse, VOL/PANL/PANR read back 0 plus the ones fill, apu_reset=1; after power-on the first tick gives len_tick (step 0).
